// File: rtl/timer_key_ctrl.sv
// timer_key_ctrl: sync + debounce seven front-panel keys into timer adjust flags, enable, mode and softrst_N.
// Latency DEB_CYC+3 cycles from first low sample, no backpressure; auto-repeat built only with TIMER_KEY_AUTOREPEAT_EN.
module timer_key_ctrl #(
  parameter int DEB_CYC   = 20,
  parameter int RPT_DLY   = 500,
  parameter int RPT_PER   = 100,
  parameter int SOFTRST_W = 4
) (
  input  logic clk,
  input  logic rst_N,
  input  logic key_incmin_N,
  input  logic key_decmin_N,
  input  logic key_inchour_N,
  input  logic key_dechour_N,
  input  logic key_run_N,
  input  logic key_mode_N,
  input  logic key_clr_N,
  output logic flag_incmin,
  output logic flag_decmin,
  output logic flag_inchour,
  output logic flag_dechour,
  output logic enable,
  output logic mode,
  output logic softrst_N
);

  localparam int NK = 7;
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int SW = $clog2(SOFTRST_W + 1);

  if (DEB_CYC < 1 || RPT_DLY < 1 || RPT_PER < 1 || SOFTRST_W < 1) begin : g_param_chk
    $error("timer_key_ctrl: all timing parameters must be >= 1");
  end

  logic [NK-1:0] raw;
  logic [NK-1:0] press;
  logic [3:0]    rel;

  assign raw = {key_clr_N, key_mode_N, key_run_N, key_dechour_N,
                key_inchour_N, key_decmin_N, key_incmin_N};

  // Per key: 2-FF synchroniser, then a debouncer that flips only after DEB_CYC disagreeing cycles.
  for (genvar k = 0; k < NK; k++) begin : g_deb
    logic          s1, s2, lvl, pr, flip;
    logic [DW-1:0] cnt;

    assign flip = (s2 != lvl) && (cnt == DW'(DEB_CYC - 1));

    always_ff @(posedge clk or negedge rst_N) begin
      if (!rst_N) begin
        s1  <= 1'b1;
        s2  <= 1'b1;
        lvl <= 1'b1;
        cnt <= '0;
        pr  <= 1'b0;
      end else begin
        s1 <= raw[k];
        s2 <= s1;
        pr <= flip && lvl;
        if (s2 == lvl) begin
          cnt <= '0;
        end else if (flip) begin
          lvl <= ~lvl;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign press[k] = pr;

    if (k < 4) begin : g_rel
      logic rl;
      always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) rl <= 1'b0;
        else        rl <= flip && !lvl;
      end
      assign rel[k] = rl;
    end
  end

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} adj_st_t;

  logic [3:0] req;

`ifdef TIMER_KEY_AUTOREPEAT_EN
  localparam int RMAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int RW   = $clog2(RMAX + 1);
`endif

  for (genvar a = 0; a < 4; a++) begin : g_adj
    adj_st_t st_q, st_d;
    logic    r;
`ifdef TIMER_KEY_AUTOREPEAT_EN
    logic [RW-1:0] cnt_q, cnt_d;
`endif

    always_ff @(posedge clk or negedge rst_N) begin
      if (!rst_N) begin
        st_q  <= ST_IDLE;
`ifdef TIMER_KEY_AUTOREPEAT_EN
        cnt_q <= '0;
`endif
      end else begin
        st_q  <= st_d;
`ifdef TIMER_KEY_AUTOREPEAT_EN
        cnt_q <= cnt_d;
`endif
      end
    end

    always_comb begin
      st_d = st_q;
`ifdef TIMER_KEY_AUTOREPEAT_EN
      cnt_d = cnt_q;
      case (st_q)
        ST_IDLE: begin
          if (press[a]) begin
            st_d  = ST_HOLD;
            cnt_d = RW'(RPT_DLY - 1);
          end
        end
        ST_HOLD: begin
          if (rel[a]) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
          end else if (cnt_q == '0) begin
            st_d  = ST_REPEAT;
            cnt_d = RW'(RPT_PER - 1);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_REPEAT: begin
          if (rel[a]) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
          end else if (cnt_q == '0) begin
            cnt_d = RW'(RPT_PER - 1);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end
      endcase
`else
      case (st_q)
        ST_IDLE: if (press[a]) st_d = ST_HOLD;
        ST_HOLD: if (rel[a])   st_d = ST_IDLE;
        default:               st_d = ST_IDLE;
      endcase
`endif
    end

    always_comb begin
      r = 1'b0;
      case (st_q)
        ST_IDLE:   r = press[a];
`ifdef TIMER_KEY_AUTOREPEAT_EN
        ST_HOLD,
        ST_REPEAT: r = !rel[a] && (cnt_q == '0);
`endif
        default:   r = 1'b0;
      endcase
    end

    assign req[a] = r;
  end

  logic [3:0]    gnt;
  logic [SW-1:0] sr_cnt_q, sr_cnt_d;
  logic          srn_d;

  // Fixed priority; losers are dropped, never queued.
  always_comb begin
    gnt = '0;
    if      (req[0]) gnt[0] = 1'b1;
    else if (req[1]) gnt[1] = 1'b1;
    else if (req[2]) gnt[2] = 1'b1;
    else if (req[3]) gnt[3] = 1'b1;
  end

  // A clear press is only accepted once the previous pulse has fully ended.
  always_comb begin
    sr_cnt_d = sr_cnt_q;
    srn_d    = 1'b1;
    if (sr_cnt_q != '0) begin
      sr_cnt_d = sr_cnt_q - 1'b1;
      srn_d    = (sr_cnt_q == SW'(1));
    end else if (press[6]) begin
      sr_cnt_d = SW'(SOFTRST_W);
      srn_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      {flag_dechour, flag_inchour, flag_decmin, flag_incmin} <= 4'b0000;
      enable    <= 1'b1;
      mode      <= 1'b0;
      softrst_N <= 1'b1;
      sr_cnt_q  <= '0;
    end else begin
      {flag_dechour, flag_inchour, flag_decmin, flag_incmin} <= gnt & {4{srn_d}};
      enable    <= enable ^ press[4];
      mode      <= mode ^ press[5];
      softrst_N <= srn_d;
      sr_cnt_q  <= sr_cnt_d;
    end
  end

endmodule
